// File: rtl/name_pkg.sv
// Shared definitions for the letter-display path (scroller and 7-segment decoder).
//   CODE_W     : width of one character code
//   BLANK_CODE : code that the decoder renders as an unlit digit
//   clog2      : ceiling log2, usable in constant expressions
package name_pkg;

  localparam int unsigned CODE_W = 4;
  localparam logic [CODE_W-1:0] BLANK_CODE = 4'hF;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v > 0) begin
        w = w + 1;
        v = v >> 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Push-key conditioner: 2-FF synchronizer followed by a falling-edge detector.
// Emits one single-cycle pulse per low-going edge of the raw key; holding the key
// low gives no repeats. No debounce is applied.
//   clk    : system clock
//   resetn : asynchronous active-low reset (sync flops reset to the released level 1)
//   key_n  : raw active-low key, asynchronous to clk
//   pulse  : one-cycle pulse after a synchronized high-to-low transition
module key_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign pulse = r_prev & ~r_sync2;

endmodule

// File: rtl/name_scroller.sv
// Scrolling message source for a row of 7-segment letter decoders.
// Holds a fixed message of 4-bit codes (optionally followed by blank padding) and
// presents a 4-code window of it; the window advances on a prescaled tick while run=1,
// or one step per key press while run=0.
//   clk      : system clock
//   resetn   : asynchronous active-low reset
//   run      : 1 = auto-scroll on tick, 0 = manual step only
//   dir      : 0 = advance (pos+1), 1 = retreat (pos-1)
//   step_n   : raw active-low push key
//   d3..d0   : registered codes at positions pos..pos+3 (d3 leftmost)
//   pos      : current window start
//   adv      : one-cycle pulse in the cycle pos takes its new value
module name_scroller
  import name_pkg::*;
#(
  parameter int unsigned          TICK_DIV   = 25_000_000,
  parameter int unsigned          MSG_LEN    = 8,
  parameter logic [4*MSG_LEN-1:0] MSG        = 32'h0123_4567,
  parameter int unsigned          PAD_LEN    = 0,
  parameter int unsigned          NUM_DIGITS = 4,
  localparam int unsigned         SEQ_LEN    = MSG_LEN + PAD_LEN,
  localparam int unsigned         PW         = (clog2(SEQ_LEN) > 0) ? clog2(SEQ_LEN) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic              dir,
  input  logic              step_n,
  output logic [CODE_W-1:0] d3,
  output logic [CODE_W-1:0] d2,
  output logic [CODE_W-1:0] d1,
  output logic [CODE_W-1:0] d0,
  output logic [PW-1:0]     pos,
  output logic              adv
);

  localparam int unsigned    CW       = clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  POS_LAST = PW'(SEQ_LEN - 1);

  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_pos;
  logic [PW-1:0]     w_pos_nxt;
  logic              r_adv;
  logic              w_tick;
  logic              w_step;
  logic              w_adv;
  logic [CODE_W-1:0] w_code [NUM_DIGITS];
  logic [CODE_W-1:0] r_d    [NUM_DIGITS];

  // Code at a sequence index; indices past the message fall in the pad and read blank.
  function automatic logic [CODE_W-1:0] code_at(input int unsigned idx);
    logic [4*MSG_LEN-1:0] sh;
    if (idx >= MSG_LEN) begin
      return BLANK_CODE;
    end
    sh = MSG >> (CODE_W * (MSG_LEN - 1 - idx));
    return sh[CODE_W-1:0];
  endfunction

  key_sync_edge u_step (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (step_n),
    .pulse  (w_step)
  );

  // Prescaler only runs in auto mode; dropping run discards the partial count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!run || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick = run && (r_cnt == CNT_LAST);
  // Key pulses are ignored while auto-scrolling.
  assign w_adv  = run ? w_tick : w_step;

  always_comb begin
    w_pos_nxt = r_pos;
    if (w_adv) begin
      if (dir) begin
        w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;
      end else begin
        w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pos <= '0;
      r_adv <= 1'b0;
    end else begin
      r_pos <= w_pos_nxt;
      r_adv <= w_adv;
    end
  end

  // Window select: (pos+k) mod SEQ_LEN. pos+k < SEQ_LEN+NUM_DIGITS, so at most
  // NUM_DIGITS conditional subtractions reduce it, even for very short sequences.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx = 32'(r_pos) + k;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
        if (idx >= SEQ_LEN) begin
          idx = idx - SEQ_LEN;
        end
      end
      w_code[k] = code_at(idx);
    end
  end

  // Output registers follow pos with one cycle of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        r_d[k] <= BLANK_CODE;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        r_d[k] <= w_code[k];
      end
    end
  end

  assign d3  = r_d[0];
  assign d2  = r_d[1];
  assign d1  = r_d[2];
  assign d0  = r_d[3];
  assign pos = r_pos;
  assign adv = r_adv;

endmodule
